// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART: register offsets,
// STATUS bit positions and the TX/RX state encodings.
package apb_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int ST_TXFULL  = 0;
    localparam int ST_TXEMPTY = 1;
    localparam int ST_RXFULL  = 2;
    localparam int ST_RXEMPTY = 3;
    localparam int ST_TXBUSY  = 4;
    localparam int ST_OE      = 5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO used for the UART TX and RX queues.
// A pop in the same cycle frees a slot for a push into a full FIFO.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] dout_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer advance for accepted pushes and pops
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + ONE;
        if (do_pop)  rd_d = rd_q + ONE;
    end

    // Pointer registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents are don't-care while empty
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/apb_uart.sv
// APB3 peripheral UART, 8N1 LSB first, 16x oversampling tick.
// Optional feature macro: UART_LOOPBACK_EN (CTRL[2] TX->RX loopback).
module apb_uart #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] BAUDDIV_RST = 16'd3
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [11:0] PADDR,
    input  logic [15:0] PWDATA,
    output logic [15:0] PRDATA,
    output logic        UARTTXD,
    input  logic        UARTRXD
);

    import apb_uart_pkg::*;

`ifdef UART_LOOPBACK_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

    logic [1:0]  addr;
    logic        wr_en, rd_en;
    logic        unused_addr;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] cnt_q, cnt_d;
    logic        oe_q, oe_d;
    logic        tick, loop, txen, rxen;
    logic [15:0] status;

    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_dout;
    logic        rx_push, rx_pop, rx_full, rx_empty, rx_ovf;
    logic [8:0]  rx_din, rx_dout;

    tx_state_e   tx_st_q, tx_st_d;
    logic [3:0]  tx_tk_q, tx_tk_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_line_q, tx_line_d;
    logic        tx_go, tx_bit_end;

    rx_state_e   rx_st_q, rx_st_d;
    logic [3:0]  rx_tk_q, rx_tk_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [1:0]  sync_q;
    logic        rx_in, rx_s;

    assign addr        = PADDR[3:2];
    assign unused_addr = ^{PADDR[11:4], PADDR[1:0]};
    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign rd_en       = PSEL & PENABLE & ~PWRITE;

    assign txen = ctrl_q[0];
    assign rxen = ctrl_q[1];
`ifdef UART_LOOPBACK_EN
    assign loop = ctrl_q[2];
`else
    assign loop = 1'b0;
`endif

    assign tick    = (cnt_q == baud_q);
    assign tx_push = wr_en && (addr == REG_DATA);
    assign rx_pop  = rd_en && (addr == REG_DATA) && !rx_empty;
    assign rx_din  = {~rx_s, rx_sh_q};
    assign rx_ovf  = rx_push & rx_full & ~rx_pop;

    assign UARTTXD = loop ? 1'b1 : tx_line_q;
    assign rx_in   = loop ? tx_line_q : UARTRXD;
    assign rx_s    = sync_q[1];

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .din_i   (PWDATA[7:0]),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .dout_o  (tx_dout)
    );

    uart_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .din_i   (rx_din),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .dout_o  (rx_dout)
    );

    // Register writes, sticky overrun flag and baud counter
    always_comb begin
        ctrl_d = ctrl_q;
        baud_d = baud_q;
        oe_d   = oe_q;
        cnt_d  = tick ? 16'd0 : cnt_q + 16'd1;
        if (wr_en) begin
            case (addr)
                REG_STATUS: if (PWDATA[ST_OE]) oe_d = 1'b0;
                REG_CTRL:   ctrl_d = PWDATA[2:0] & CTRL_MASK;
                REG_BAUD: begin
                    baud_d = PWDATA;
                    cnt_d  = 16'd0;
                end
                default: ;
            endcase
        end
        if (rx_ovf) oe_d = 1'b1;
    end

    // Status word and combinational read mux
    always_comb begin
        status             = '0;
        status[ST_TXFULL]  = tx_full;
        status[ST_TXEMPTY] = tx_empty;
        status[ST_RXFULL]  = rx_full;
        status[ST_RXEMPTY] = rx_empty;
        status[ST_TXBUSY]  = (tx_st_q != TX_IDLE);
        status[ST_OE]      = oe_q;
        PRDATA             = '0;
        if (rd_en) begin
            case (addr)
                REG_DATA:   if (!rx_empty) PRDATA = {7'd0, rx_dout};
                REG_STATUS: PRDATA = status;
                REG_CTRL:   PRDATA = {13'd0, ctrl_q};
                default:    PRDATA = baud_q;
            endcase
        end
    end

    assign tx_go      = txen & ~tx_empty;
    assign tx_bit_end = tick && (tx_tk_q == 4'd15);

    // TX framing: start, 8 data bits, stop; chains frames without gap
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_tk_d  = tx_tk_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_pop   = 1'b0;
        if (tick && tx_st_q != TX_IDLE) tx_tk_d = tx_tk_q + 4'd1;
        case (tx_st_q)
            TX_IDLE: if (tx_go) begin
                tx_pop  = 1'b1;
                tx_sh_d = tx_dout;
                tx_tk_d = 4'd0;
                tx_st_d = TX_START;
            end
            TX_START: if (tx_bit_end) begin
                tx_bit_d = 3'd0;
                tx_st_d  = TX_DATA;
            end
            TX_DATA: if (tx_bit_end) begin
                tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_st_d = TX_STOP;
            end
            TX_STOP: if (tx_bit_end) begin
                if (tx_go) begin
                    tx_pop  = 1'b1;
                    tx_sh_d = tx_dout;
                    tx_st_d = TX_START;
                end else begin
                    tx_st_d = TX_IDLE;
                end
            end
            default: tx_st_d = TX_IDLE;
        endcase
        tx_line_d = 1'b1;
        if (tx_st_d == TX_START)     tx_line_d = 1'b0;
        else if (tx_st_d == TX_DATA) tx_line_d = tx_sh_d[0];
    end

    // RX framing: mid-bit sampling from the start-bit edge
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_tk_d  = rx_tk_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_push  = 1'b0;
        if (tick && rx_st_q != RX_IDLE) rx_tk_d = rx_tk_q + 4'd1;
        case (rx_st_q)
            RX_IDLE: if (rxen && !rx_s) begin
                rx_tk_d = 4'd0;
                rx_st_d = RX_START;
            end
            RX_START: if (tick && rx_tk_q == 4'd7) begin
                rx_tk_d  = 4'd0;
                rx_bit_d = 3'd0;
                rx_st_d  = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (tick && rx_tk_q == 4'd15) begin
                rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            RX_STOP: if (tick && rx_tk_q == 4'd15) begin
                rx_push = 1'b1;
                rx_st_d = RX_IDLE;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // All control and datapath state
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_q    <= '0;
            baud_q    <= BAUDDIV_RST;
            cnt_q     <= '0;
            oe_q      <= 1'b0;
            tx_st_q   <= TX_IDLE;
            tx_tk_q   <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            tx_line_q <= 1'b1;
            rx_st_q   <= RX_IDLE;
            rx_tk_q   <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            sync_q    <= 2'b11;
        end else begin
            ctrl_q    <= ctrl_d;
            baud_q    <= baud_d;
            cnt_q     <= cnt_d;
            oe_q      <= oe_d;
            tx_st_q   <= tx_st_d;
            tx_tk_q   <= tx_tk_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            tx_line_q <= tx_line_d;
            rx_st_q   <= rx_st_d;
            rx_tk_q   <= rx_tk_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            sync_q    <= {sync_q[0], rx_in};
        end
    end

endmodule

// File: tb/tb_apb_uart.sv
// Directed-random bench for apb_uart with a queue-based
// reference model of the FIFOs, status flags and serial frames.
module tb_apb_uart;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [11:0] PADDR;
    logic [15:0] PWDATA;
    logic [15:0] PRDATA;
    logic        UARTTXD;
    logic        UARTRXD;

    int total = 0;
    int bad   = 0;

    logic [7:0] txm[$];
    logic [8:0] rxm[$];
    logic [8:0] got[$];
    logic       oe_m;

    always #5 PCLK = ~PCLK;

    apb_uart #(.FIFO_DEPTH(8), .BAUDDIV_RST(16'd3)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .UARTTXD (UARTTXD),
        .UARTRXD (UARTRXD)
    );

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apb_wr(logic [1:0] a, logic [15:0] d);
        @(negedge PCLK);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = {8'($urandom), a, 2'($urandom)};
        PWDATA  = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic apb_rd(logic [1:0] a, output logic [15:0] d);
        @(negedge PCLK);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = {8'($urandom), a, 2'($urandom)};
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    function automatic logic [15:0] st_exp(logic busy);
        return {10'd0, oe_m, busy, rxm.size() == 0, rxm.size() == 8,
                txm.size() == 0, txm.size() == 8};
    endfunction

    task automatic chk_status(string tag);
        logic [15:0] v;
        apb_rd(2'd1, v);
        check(tag, v, st_exp(1'b0));
    endtask

    task automatic chk_rx(string tag);
        logic [15:0] v;
        logic [15:0] e;
        apb_rd(2'd0, v);
        e = (rxm.size() == 0) ? 16'd0 : 16'(rxm.pop_front());
        check(tag, v, e);
    endtask

    task automatic tx_put(logic [7:0] b);
        apb_wr(2'd0, {8'($urandom), b});
        if (txm.size() < 8) txm.push_back(b);
    endtask

    // Mid-bit sampling of n consecutive frames with bw PCLKs per bit.
    task automatic cap(int n, int bw);
        int k = 0;
        logic [8:0] fr;
        while (UARTTXD !== 1'b0 && k < 4000) begin
            @(negedge PCLK);
            k++;
        end
        check("tx_start_seen", {15'd0, UARTTXD}, 16'd0);
        if (UARTTXD !== 1'b0) return;
        repeat (bw / 2) @(negedge PCLK);
        for (int f = 0; f < n; f++) begin
            check("tx_start_bit", {15'd0, UARTTXD}, 16'd0);
            for (int i = 0; i < 9; i++) begin
                repeat (bw) @(negedge PCLK);
                fr[i] = UARTTXD;
            end
            got.push_back(fr);
            if (f < n - 1) repeat (bw) @(negedge PCLK);
        end
    endtask

    task automatic chk_frames(string tag);
        while (got.size() > 0) begin
            logic [8:0] g;
            logic [8:0] e;
            g = got.pop_front();
            e = (txm.size() == 0) ? 9'h0 : {1'b1, txm.pop_front()};
            check(tag, 16'(g), 16'(e));
        end
    endtask

    task automatic rx_frame(logic [7:0] b, logic stopb, logic en);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            UARTRXD = f[i];
            repeat (16) @(negedge PCLK);
        end
        UARTRXD = 1'b1;
        if (en) begin
            if (rxm.size() == 8) oe_m = 1'b1;
            else rxm.push_back({~stopb, b});
        end
    endtask

    task automatic chk_quiet(string tag, int cyc);
        int hi = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge PCLK);
            if (UARTTXD === 1'b1) hi++;
        end
        check(tag, 16'(hi), 16'(cyc));
    endtask

    initial begin
        logic [15:0] v;
        logic [7:0]  b;
        int          lows;

        PRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        UARTRXD = 1'b1;
        oe_m    = 1'b0;
        #1 check("rst_txd", {15'd0, UARTTXD}, 16'd1);
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;

        // reset state
        #1 check("rst_prdata_idle", PRDATA, 16'd0);
        chk_status("rst_status");
        apb_rd(2'd3, v);
        check("rst_baud", v, 16'h0003);
        apb_rd(2'd2, v);
        check("rst_ctrl", v, 16'h0000);
        chk_rx("rst_data_empty");

        // TX 0x55 at one tick per PCLK
        apb_wr(2'd3, 16'd0);
        apb_wr(2'd2, 16'd1);
        tx_put(8'h55);
        lows = 0;
        while (UARTTXD !== 1'b0 && lows < 100) begin
            @(negedge PCLK);
            lows++;
        end
        lows = 0;
        while (UARTTXD === 1'b0 && lows < 100) begin
            @(negedge PCLK);
            lows++;
        end
        check("tx55_start_len", 16'(lows), 16'd16);
        repeat (8) @(negedge PCLK);
        for (int i = 0; i < 9; i++) begin
            got.push_back({UARTTXD, 8'h00});
            repeat (16) @(negedge PCLK);
        end
        for (int i = 0; i < 9; i++) begin
            logic [8:0] g;
            g = got.pop_front();
            check("tx55_bit", {15'd0, g[8]}, (i == 8) ? 16'd1 : 16'(i % 2 == 0));
        end
        void'(txm.pop_front());
        chk_status("tx55_done_status");

        // fill TX FIFO past full, then drain back-to-back
        apb_wr(2'd2, 16'd0);
        for (int i = 0; i < 9; i++) tx_put(8'($urandom));
        chk_status("tx_full_status");
        apb_wr(2'd2, 16'd1);
        cap(8, 16);
        chk_frames("tx_burst_frame");
        chk_quiet("tx_drop_ninth", 200);
        chk_status("tx_burst_done");

        // TXEN cleared mid-frame finishes that frame only
        apb_wr(2'd2, 16'd0);
        tx_put(8'($urandom));
        b = 8'($urandom);
        tx_put(b);
        fork
            cap(1, 16);
            begin
                apb_wr(2'd2, 16'd1);
                repeat (40) @(negedge PCLK);
                apb_wr(2'd2, 16'd0);
            end
        join
        chk_frames("tx_txen_off_frame");
        chk_quiet("tx_txen_off_quiet", 200);
        chk_status("tx_txen_off_status");
        fork
            cap(1, 16);
            apb_wr(2'd2, 16'd1);
        join
        chk_frames("tx_txen_resume");

        // slower baud
        apb_wr(2'd3, 16'd2);
        apb_rd(2'd3, v);
        check("baud_rw", v, 16'd2);
        tx_put(8'($urandom));
        cap(1, 48);
        chk_frames("tx_baud2_frame");
        repeat (30) @(negedge PCLK);
        apb_wr(2'd3, 16'd0);

        // RX 0xA3 then random back-to-back bytes
        apb_wr(2'd2, 16'd2);
        rx_frame(8'hA3, 1'b1, 1'b1);
        repeat (4) @(negedge PCLK);
        chk_status("rx_a3_status");
        chk_rx("rx_a3_data");
        chk_status("rx_a3_empty");
        for (int i = 0; i < 3; i++) rx_frame(8'($urandom), 1'b1, 1'b1);
        repeat (4) @(negedge PCLK);
        for (int i = 0; i < 4; i++) chk_rx("rx_rand_data");

        // framing error
        rx_frame(8'($urandom), 1'b0, 1'b1);
        repeat (40) @(negedge PCLK);
        chk_rx("rx_framing");

        // short low pulse is rejected as a glitch
        UARTRXD = 1'b0;
        repeat (4) @(negedge PCLK);
        UARTRXD = 1'b1;
        repeat (40) @(negedge PCLK);
        chk_status("rx_glitch");

        // RXEN off ignores traffic
        apb_wr(2'd2, 16'd0);
        rx_frame(8'($urandom), 1'b1, 1'b0);
        repeat (4) @(negedge PCLK);
        chk_status("rx_disabled");

        // overrun on the ninth unread byte
        apb_wr(2'd2, 16'd2);
        for (int i = 0; i < 9; i++) rx_frame(8'($urandom), 1'b1, 1'b1);
        repeat (4) @(negedge PCLK);
        chk_status("rx_ovr_status");
        apb_wr(2'd1, 16'h001F);
        chk_status("rx_ovr_keep");
        for (int i = 0; i < 9; i++) chk_rx("rx_ovr_data");
        apb_wr(2'd1, 16'h0020);
        oe_m = 1'b0;
        chk_status("rx_ovr_clear");

`ifdef UART_LOOPBACK_EN
        apb_wr(2'd2, 16'd7);
        tx_put(8'h3C);
        chk_quiet("loop_txd_high", 200);
        void'(txm.pop_front());
        rxm.push_back(9'h03C);
        chk_rx("loop_data");
`else
        apb_wr(2'd2, 16'd7);
        apb_rd(2'd2, v);
        check("ctrl_loop_masked", v, 16'd3);
`endif
        apb_wr(2'd2, 16'd0);

        // reset in the middle of a frame
        apb_wr(2'd2, 16'd1);
        tx_put(8'h00);
        repeat (60) @(negedge PCLK);
        check("midframe_low", {15'd0, UARTTXD}, 16'd0);
        PRESET = 1'b1;
        #1 check("midframe_rst_txd", {15'd0, UARTTXD}, 16'd1);
        txm.delete();
        rxm.delete();
        oe_m = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        chk_status("midframe_rst_status");
        apb_rd(2'd3, v);
        check("midframe_rst_baud", v, 16'h0003);
        chk_quiet("midframe_rst_quiet", 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
